// File: rtl/step_move_sequencer.sv
// Stepper move sequencer: a small command FIFO feeding a move FSM that drives
// ST_CLK/ST_DIR/ST_ENB, with a direction-setup delay ahead of every move.
module step_move_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIR_SETUP  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          LClk,
  input  logic                          rst,
  input  logic                          cmd_wr,
  input  logic [CNT_W-1:0]              cmd_steps,
  input  logic [CNT_W-1:0]              cmd_half_period,
  input  logic                          cmd_dir,
  input  logic                          abort,
  input  logic                          clr_err,
  output logic                          ST_CLK,
  output logic                          ST_DIR,
  output logic                          ST_ENB,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              steps_done,
  output logic                          move_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_L    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE    = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Command storage; pointers carry one extra bit to separate full from empty.
  logic [CNT_W-1:0] mem_steps [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_hp    [FIFO_DEPTH];
  logic             mem_dir   [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  logic             pop;
  logic             push_ok;
  logic             drop;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] w_steps, w_steps_nxt;
  logic [CNT_W-1:0] w_hp, w_hp_nxt;
  logic [CNT_W-1:0] steps_done_nxt;
  logic             st_clk_nxt;
  logic             st_dir_nxt;
  logic             st_enb_nxt;
  logic             move_done_nxt;
  logic [CNT_W-1:0] head_steps;
  logic [CNT_W-1:0] head_hp;
  logic             head_dir;

  assign wr_addr    = wr_ptr[AW-1:0];
  assign rd_addr    = rd_ptr[AW-1:0];
  assign head_steps = mem_steps[rd_addr];
  assign head_hp    = mem_hp[rd_addr];
  assign head_dir   = mem_dir[rd_addr];

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_level == {(AW+1){1'b0}});
  assign fifo_full  = (fifo_level == DEPTH_L);
  assign busy       = (state != IDLE) | ~fifo_empty;

  // A full FIFO still accepts a push when the FSM pops in the same cycle;
  // a push coinciding with abort is discarded silently.
  assign push_ok = cmd_wr & ~abort & (~fifo_full | pop);
  assign drop    = cmd_wr & ~abort & fifo_full & ~pop;

  // Command payload storage (data only, no reset needed)
  always_ff @(posedge LClk) begin
    if (push_ok && !rst) begin
      mem_steps[wr_addr] <= cmd_steps;
      mem_hp[wr_addr]    <= cmd_half_period;
      mem_dir[wr_addr]   <= cmd_dir;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge LClk) begin
    if (rst) begin
      wr_ptr   <= {(AW+1){1'b0}};
      rd_ptr   <= {(AW+1){1'b0}};
      overflow <= 1'b0;
    end else begin
      if (abort) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

  // FSM state, timing counter, working registers and driver outputs
  always_ff @(posedge LClk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= CNT_ZERO;
      w_steps    <= CNT_ZERO;
      w_hp       <= CNT_ONE;
      steps_done <= CNT_ZERO;
      ST_CLK     <= 1'b0;
      ST_DIR     <= 1'b0;
      ST_ENB     <= 1'b0;
      move_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      w_steps    <= w_steps_nxt;
      w_hp       <= w_hp_nxt;
      steps_done <= steps_done_nxt;
      ST_CLK     <= st_clk_nxt;
      ST_DIR     <= st_dir_nxt;
      ST_ENB     <= st_enb_nxt;
      move_done  <= move_done_nxt;
    end
  end

  // Next-state and next-output logic for the move FSM
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    w_steps_nxt    = w_steps;
    w_hp_nxt       = w_hp;
    steps_done_nxt = steps_done;
    st_clk_nxt     = ST_CLK;
    st_dir_nxt     = ST_DIR;
    st_enb_nxt     = ST_ENB;
    move_done_nxt  = 1'b0;
    pop            = 1'b0;

    case (state)
      IDLE: begin
        st_clk_nxt = 1'b0;
        st_enb_nxt = 1'b0;
        if (!fifo_empty) begin
          pop            = 1'b1;
          w_steps_nxt    = head_steps;
          w_hp_nxt       = (head_hp == CNT_ZERO) ? CNT_ONE : head_hp;
          steps_done_nxt = CNT_ZERO;
          cnt_nxt        = CNT_ZERO;
          if (head_steps == CNT_ZERO) begin
            state_nxt     = DONE;
            move_done_nxt = 1'b1;
          end else begin
            st_dir_nxt = head_dir;
            st_enb_nxt = 1'b1;
            state_nxt  = SETUP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt  = HIGH;
          st_clk_nxt = 1'b1;
          cnt_nxt    = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt == w_hp - CNT_ONE) begin
          state_nxt      = LOW;
          st_clk_nxt     = 1'b0;
          steps_done_nxt = steps_done + CNT_ONE;
          cnt_nxt        = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      LOW: begin
        if (cnt == w_hp - CNT_ONE) begin
          cnt_nxt = CNT_ZERO;
          if (steps_done == w_steps) begin
            state_nxt     = DONE;
            move_done_nxt = 1'b1;
          end else begin
            state_nxt  = HIGH;
            st_clk_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        st_clk_nxt = 1'b0;
        st_enb_nxt = 1'b0;
      end
      default: begin
        state_nxt  = IDLE;
        st_clk_nxt = 1'b0;
        st_enb_nxt = 1'b0;
      end
    endcase

    // Abort discards the queue and parks the driver, keeping ST_DIR and progress.
    if (abort) begin
      state_nxt     = IDLE;
      st_clk_nxt    = 1'b0;
      st_enb_nxt    = 1'b0;
      move_done_nxt = 1'b0;
      pop           = 1'b0;
    end else begin
      pop = pop;
    end
  end

endmodule
